// File: rtl/piano_voice_arbiter_if.sv
// Key/tone bundle between the piano front panel and the monophonic voice
// controller. The controller side uses the slave modport.
interface piano_voice_arbiter_if;
  logic [7:0] keys;
  logic       mute;
  logic       tone;
  logic       note_on;
  logic [2:0] active_idx;
  logic       note_change;

  modport master (
    output keys,
    output mute,
    input  tone,
    input  note_on,
    input  active_idx,
    input  note_change
  );

  modport slave (
    input  keys,
    input  mute,
    output tone,
    output note_on,
    output active_idx,
    output note_change
  );
endinterface

// File: rtl/piano_voice_arbiter.sv
// Monophonic voice controller: synchronises and debounces eight key buttons
// (C4..C5), selects one sounding note with last-pressed priority, and drives a
// single time-shared square-wave divider with that note's half-period.
module piano_voice_arbiter #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 17
) (
  input logic                  clk,
  input logic                  reset,
  piano_voice_arbiter_if.slave bus
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Half-period in clock cycles for each key, floor(CLK_HZ / (2 * F)).
  function automatic logic [CNT_W-1:0] half_period(input logic [2:0] idx);
    case (idx)
      3'd0:    half_period = CNT_W'(CLK_HZ / (2 * 262));
      3'd1:    half_period = CNT_W'(CLK_HZ / (2 * 294));
      3'd2:    half_period = CNT_W'(CLK_HZ / (2 * 330));
      3'd3:    half_period = CNT_W'(CLK_HZ / (2 * 349));
      3'd4:    half_period = CNT_W'(CLK_HZ / (2 * 392));
      3'd5:    half_period = CNT_W'(CLK_HZ / (2 * 440));
      3'd6:    half_period = CNT_W'(CLK_HZ / (2 * 494));
      default: half_period = CNT_W'(CLK_HZ / (2 * 523));
    endcase
  endfunction

  // Index of the highest set bit; 0 for an empty vector.
  function automatic logic [2:0] top_bit(input logic [7:0] v);
    top_bit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) top_bit = 3'(i);
    end
  endfunction

  logic [7:0]       sync_p0;
  logic [7:0]       sync_p1;
  logic [7:0]       sync_prev;
  logic [7:0]       deb;
  logic [7:0]       deb_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic [2:0]       active_idx_q;
  logic             note_on_q;
  logic             note_change_q;
  logic [CNT_W-1:0] tone_cnt;
  logic             tone_q;

  logic [7:0]       new_keys;
  logic [2:0]       idx_nxt;
  logic             on_nxt;
  logic             change_nxt;

  // Two-flop synchroniser per key, plus last cycle's synchronised value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      sync_prev <= '0;
    end else begin
      sync_p0   <= bus.keys;
      sync_p1   <= sync_p0;
      sync_prev <= sync_p1;
    end
  end

  // Shared debounce counter: a new key pattern is accepted only after it has
  // been stable for DEBOUNCE_CYCLES cycles; any movement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb     <= '0;
      deb_cnt <= '0;
    end else if ((sync_p1 != sync_prev) || (sync_p1 == deb)) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
      deb     <= sync_p1;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Last-pressed priority: a fresh press wins (highest index on ties); if the
  // sounding key is released, fall back to the highest key still held.
  always_comb begin
    new_keys = deb & ~deb_prev;
    idx_nxt  = active_idx_q;
    on_nxt   = |deb;
    if (new_keys != 8'd0) begin
      idx_nxt = top_bit(new_keys);
    end else if (deb_prev[active_idx_q] && !deb[active_idx_q]) begin
      idx_nxt = (deb == 8'd0) ? 3'd0 : top_bit(deb);
    end
    change_nxt = (idx_nxt != active_idx_q) || (on_nxt != note_on_q);
  end

  // Registered arbitration outputs and the one-cycle change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_prev      <= '0;
      active_idx_q  <= '0;
      note_on_q     <= 1'b0;
      note_change_q <= 1'b0;
    end else begin
      deb_prev      <= deb;
      active_idx_q  <= idx_nxt;
      note_on_q     <= on_nxt;
      note_change_q <= change_nxt;
    end
  end

  // Shared tone divider: restarts on every note change without touching the
  // output level, so a new pitch always begins with a full half-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (!note_on_q) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (note_change_q) begin
      tone_cnt <= '0;
    end else if (tone_cnt == half_period(active_idx_q) - 1'b1) begin
      tone_cnt <= '0;
      tone_q   <= ~tone_q;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  // Mute gates only the output, so the divider keeps its phase while muted.
  assign bus.tone        = tone_q & ~bus.mute;
  assign bus.note_on     = note_on_q;
  assign bus.active_idx  = active_idx_q;
  assign bus.note_change = note_change_q;

endmodule

// File: tb/tb_piano_voice_arbiter.sv
// Scoreboard bench for piano_voice_arbiter at a scaled-down clock rate so the
// debounce interval and tone periods fit a short run.
module tb_piano_voice_arbiter;

  localparam int CLK_HZ   = 500000;
  localparam int DEB      = 50;
  localparam int CNT_W    = 17;
  localparam int LAT_MIN  = DEB + 2;
  localparam int LAT_MAX  = DEB + 4;
  localparam int MUTE_LEN = 2000;
  // floor(500000 / (2*F)) for F = 262,294,330,349,392,440,494,523
  localparam int HALF [0:7] = '{954, 850, 757, 716, 637, 568, 506, 478};

  typedef struct packed {
    logic       on;
    logic [2:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   chg_count = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  piano_voice_arbiter_if vif();

  piano_voice_arbiter #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(vif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vif.note_change === 1'b1) chg_count <= chg_count + 1;
  end

  initial begin
    #(10 * 300000);
    $display("FAIL watchdog: simulation exceeded %0d cycles", 300000);
    $fatal(1, "watchdog");
  end

  task automatic drive_keys(input logic [7:0] k, input logic on, input logic [2:0] idx);
    exp_t e;
    @(negedge clk);
    vif.keys = k;
    e.on = on;
    e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic wait_change(input int budget, output bit ok, output int lat);
    int t0;
    t0 = cyc;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (vif.note_change === 1'b1) begin
        ok = 1'b1;
        lat = cyc - t0;
      end
    end
  endtask

  task automatic wait_tone_edge(input int budget, output bit ok, output int t);
    logic prev;
    prev = vif.tone;
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (vif.tone !== prev) begin
        ok = 1'b1;
        t = cyc;
      end
    end
  endtask

  task automatic measure(input int budget, output bit ok, output int a, output int b,
                         output int t_last);
    bit ok1, ok2, ok3;
    int t1, t2, t3;
    wait_tone_edge(budget, ok1, t1);
    wait_tone_edge(budget, ok2, t2);
    wait_tone_edge(budget, ok3, t3);
    ok = ok1 && ok2 && ok3;
    a = t2 - t1;
    b = t3 - t2;
    t_last = t3;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    vif.keys = 8'h00;
    vif.mute = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (vif.tone !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tone: got %b expected 0", vif.tone);
    end
    vectors++;
    if (vif.note_on !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_note_on: got %b expected 0", vif.note_on);
    end
    vectors++;
    if (vif.active_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_active_idx: got %0d expected 0", vif.active_idx);
    end
    vectors++;
    if (vif.note_change !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_note_change: got %b expected 0", vif.note_change);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_press;
    bit ok;
    int lat, a, b, tl, c0;
    exp_t e;
    c0 = chg_count;
    drive_keys(8'h04, 1'b1, 3'd2);
    wait_change(DEB + 20, ok, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
      miscompares++;
      $display("FAIL press_e4: ok=%0d on=%b idx=%0d expected on=%b idx=%0d",
               ok, vif.note_on, vif.active_idx, e.on, e.idx);
    end
    vectors++;
    if (lat < LAT_MIN || lat > LAT_MAX) begin
      miscompares++;
      $display("FAIL press_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
    end
    @(negedge clk);
    vectors++;
    if (vif.note_change !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: note_change still %b one cycle later, expected 0",
               vif.note_change);
    end
    measure(2 * HALF[2] + 10, ok, a, b, tl);
    vectors++;
    if (!ok || a != HALF[2] || b != HALF[2]) begin
      miscompares++;
      $display("FAIL e4_period: ok=%0d levels %0d/%0d expected %0d", ok, a, b, HALF[2]);
    end
    vectors++;
    if (chg_count - c0 != 1) begin
      miscompares++;
      $display("FAIL e4_pulses: got %0d note_change pulses expected 1", chg_count - c0);
    end
    drive_keys(8'h00, 1'b0, 3'd0);
    wait_change(DEB + 20, ok, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    @(negedge clk);
    vectors++;
    if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx || vif.tone !== 1'b0) begin
      miscompares++;
      $display("FAIL release_e4: ok=%0d on=%b idx=%0d tone=%b expected on=0 idx=0 tone=0",
               ok, vif.note_on, vif.active_idx, vif.tone);
    end
  endtask

  task automatic test_priority;
    logic [7:0] k_tab [0:3];
    bit ok;
    int lat, a, b, tl, c0;
    exp_t e;
    exp_t x_tab [0:3];
    k_tab = '{8'h01, 8'h21, 8'h01, 8'h00};
    x_tab = '{'{1'b1, 3'd0}, '{1'b1, 3'd5}, '{1'b1, 3'd0}, '{1'b0, 3'd0}};
    for (int i = 0; i < 4; i++) begin
      c0 = chg_count;
      drive_keys(k_tab[i], x_tab[i].on, x_tab[i].idx);
      wait_change(DEB + 20, ok, lat);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
        miscompares++;
        $display("FAIL priority_step%0d: ok=%0d on=%b idx=%0d expected on=%b idx=%0d",
                 i, ok, vif.note_on, vif.active_idx, e.on, e.idx);
      end
      if (e.on) begin
        measure(2 * HALF[e.idx] + 10, ok, a, b, tl);
        vectors++;
        if (!ok || a != HALF[e.idx] || b != HALF[e.idx]) begin
          miscompares++;
          $display("FAIL priority_period%0d: ok=%0d levels %0d/%0d expected %0d",
                   i, ok, a, b, HALF[e.idx]);
        end
      end else begin
        repeat (3) @(negedge clk);
        vectors++;
        if (vif.tone !== 1'b0) begin
          miscompares++;
          $display("FAIL priority_silent: tone=%b expected 0", vif.tone);
        end
      end
      vectors++;
      if (chg_count - c0 != 1) begin
        miscompares++;
        $display("FAIL priority_pulses%0d: got %0d pulses expected 1", i, chg_count - c0);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [7:0] k_tab [0:2];
    exp_t x_tab [0:2];
    bit ok;
    int lat, c0;
    exp_t e;
    k_tab = '{8'h12, 8'h02, 8'h00};
    x_tab = '{'{1'b1, 3'd4}, '{1'b1, 3'd1}, '{1'b0, 3'd0}};
    for (int i = 0; i < 3; i++) begin
      c0 = chg_count;
      drive_keys(k_tab[i], x_tab[i].on, x_tab[i].idx);
      wait_change(DEB + 20, ok, lat);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
        miscompares++;
        $display("FAIL simul_step%0d: ok=%0d on=%b idx=%0d expected on=%b idx=%0d",
                 i, ok, vif.note_on, vif.active_idx, e.on, e.idx);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (chg_count - c0 != 1) begin
        miscompares++;
        $display("FAIL simul_pulses%0d: got %0d pulses expected 1", i, chg_count - c0);
      end
    end
    vectors++;
    if (vif.tone !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_tone: tone=%b expected 0 after release", vif.tone);
    end
  endtask

  task automatic test_bounce;
    int c0, bad;
    c0 = chg_count;
    bad = 0;
    for (int burst = 0; burst < 5; burst++) begin
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        vif.keys = (j < 20) ? 8'h80 : 8'h00;
        if (vif.note_on !== 1'b0 || vif.tone !== 1'b0) bad++;
      end
    end
    repeat (DEB + 10) begin
      @(negedge clk);
      if (vif.note_on !== 1'b0 || vif.tone !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bounce_outputs: %0d cycles with note_on/tone high, expected 0", bad);
    end
    vectors++;
    if (chg_count - c0 != 0) begin
      miscompares++;
      $display("FAIL bounce_pulses: got %0d note_change pulses expected 0", chg_count - c0);
    end
  endtask

  task automatic test_mute;
    bit ok;
    int lat, a, b, t_ref, t4, bad;
    exp_t e;
    drive_keys(8'h80, 1'b1, 3'd7);
    wait_change(DEB + 20, ok, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
      miscompares++;
      $display("FAIL mute_c5_on: ok=%0d on=%b idx=%0d expected on=%b idx=%0d",
               ok, vif.note_on, vif.active_idx, e.on, e.idx);
    end
    measure(2 * HALF[7] + 10, ok, a, b, t_ref);
    vectors++;
    if (!ok || a != HALF[7] || b != HALF[7]) begin
      miscompares++;
      $display("FAIL c5_period: ok=%0d levels %0d/%0d expected %0d", ok, a, b, HALF[7]);
    end
    @(negedge clk);
    vif.mute = 1'b1;
    bad = 0;
    repeat (MUTE_LEN) begin
      #1;
      if (vif.tone !== 1'b0 || vif.note_on !== 1'b1) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mute_hold: %0d cycles with tone!=0 or note_on!=1, expected 0", bad);
    end
    vif.mute = 1'b0;
    @(negedge clk);
    wait_tone_edge(2 * HALF[7] + 10, ok, t4);
    vectors++;
    if (!ok || ((t4 - t_ref) % HALF[7]) != 0) begin
      miscompares++;
      $display("FAIL unmute_phase: ok=%0d offset %0d mod %0d = %0d expected 0",
               ok, t4 - t_ref, HALF[7], (t4 - t_ref) % HALF[7]);
    end
    drive_keys(8'h00, 1'b0, 3'd0);
    wait_change(DEB + 20, ok, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
      miscompares++;
      $display("FAIL mute_release: ok=%0d on=%b idx=%0d expected on=0 idx=0",
               ok, vif.note_on, vif.active_idx);
    end
  endtask

  task automatic test_reset_mid_note;
    bit ok;
    int lat, t;
    exp_t e;
    drive_keys(8'h40, 1'b1, 3'd6);
    wait_change(DEB + 20, ok, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
      miscompares++;
      $display("FAIL b4_on: ok=%0d on=%b idx=%0d expected on=%b idx=%0d",
               ok, vif.note_on, vif.active_idx, e.on, e.idx);
    end
    wait_tone_edge(2 * HALF[6] + 10, ok, t);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (vif.tone !== 1'b0 || vif.note_on !== 1'b0 || vif.active_idx !== 3'd0 ||
        vif.note_change !== 1'b0) begin
      miscompares++;
      $display("FAIL midnote_reset: tone=%b on=%b idx=%0d chg=%b expected all 0",
               vif.tone, vif.note_on, vif.active_idx, vif.note_change);
    end
    reset = 1'b0;
    e.on = 1'b1;
    e.idx = 3'd6;
    sb.push_back(e);
    wait_change(DEB + 20, ok, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
      miscompares++;
      $display("FAIL b4_resound: ok=%0d on=%b idx=%0d expected on=%b idx=%0d",
               ok, vif.note_on, vif.active_idx, e.on, e.idx);
    end
    vectors++;
    if (lat < LAT_MIN || lat > LAT_MAX) begin
      miscompares++;
      $display("FAIL resound_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
    end
    drive_keys(8'h00, 1'b0, 3'd0);
    wait_change(DEB + 20, ok, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    vectors++;
    if (!ok || vif.note_on !== e.on || vif.active_idx !== e.idx) begin
      miscompares++;
      $display("FAIL b4_release: ok=%0d on=%b idx=%0d expected on=0 idx=0",
               ok, vif.note_on, vif.active_idx);
    end
  endtask

  initial begin
    vif.keys = 8'h00;
    vif.mute = 1'b0;
    test_reset();
    test_clean_press();
    test_priority();
    test_simultaneous();
    test_bounce();
    test_mute();
    test_reset_mid_note();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piano_voice_arbiter.md
Name: piano_voice_arbiter

Overview:
- Monophonic voice controller for the digital piano.
- Takes eight raw key buttons (C4..C5) and synchronises and debounces them.
- Picks exactly one sounding note using last-pressed priority.
- Drives a single shared square-wave tone divider with that note's half-period count.
- Replaces one free-running divider per note: one divider is time-shared among all keys.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz; all half-period constants derive from it.
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised cycles required to accept a key change (10 ms at default).
- CNT_W, 17: tone counter width; must satisfy 2^CNT_W > largest half-period.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- keys  input  8  raw asynchronous buttons; bit0=C4, 1=D4, 2=E4, 3=F4, 4=G4, 5=A4, 6=B4, 7=C5.
- mute  input  1  synchronous; forces tone low while high; arbitration continues.
- tone  output  1  square-wave audio output.
- note_on  output  1  high while any debounced key is held.
- active_idx  output  3  index of sounding key; 0 when note_on=0.
- note_change  output  1  one-cycle pulse whenever active_idx or note_on changes.

Behaviour:
- Reset (synchronous, active-high): all registers clear.
  - Outputs: tone=0, note_on=0, active_idx=0, note_change=0.
  - Internal: synchroniser=0, debounced state=0, debounce count=0, tone counter=0.
  - Reset mid-note silences on the next edge.
- Synchroniser: two flops per key, giving sync[7:0].
- Debounce: one shared counter; sync_prev holds the previous cycle's sync value.
  - Counter clears when sync != sync_prev or when sync == deb.
  - Otherwise it increments.
  - When count == DEBOUNCE_CYCLES-1 and sync != deb: deb <= sync, and the counter clears.
- Arbitration: registered, evaluated on deb and deb_prev.
  - new = deb & ~deb_prev.
  - If new != 0: active_idx <= highest set bit of new. Simultaneous presses go to the higher index.
  - Else if deb[active_idx] fell: active_idx <= highest set bit still in deb. If deb == 0, note_on <= 0 and active_idx <= 0.
  - Otherwise the selection holds.
  - note_on <= |deb.
  - note_change is registered and pulses one cycle when either output differs from its prior value.
- Latency: raw key edge to note_on/active_idx update is DEBOUNCE_CYCLES+3 cycles for a clean edge (2 sync, DEBOUNCE_CYCLES stable, 1 arbitration), ±1.
- Half-period table: HALF[i] = floor(CLK_HZ / (2*F_i)), with F = 262, 294, 330, 349, 392, 440, 494, 523 Hz.
  - Defaults: 95419, 85034, 75757, 71633, 63775, 56818, 50607, 47801.
- Tone divider:
  - When note_on=1: counter increments each cycle. At counter == HALF[active_idx]-1, tone toggles and the counter returns to 0. Each level therefore lasts HALF cycles.
  - On the cycle note_change=1, the counter clears and tone keeps its level, so the new pitch starts with a full half-period and no runt pulse.
  - When note_on=0: counter held at 0, tone=0.
  - mute=1: tone forced 0 combinationally after its register; the counter still runs, so unmute resumes in phase.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES never changes deb, note_on or tone.

Test Plan:
- Reset then press E4 (keys=8'h04) clean:
  - note_on rises DEBOUNCE_CYCLES+3 (±1) cycles later with active_idx=2 and one note_change pulse.
  - tone high/low periods are exactly 75757 cycles each.
- Hold C4, then press A4:
  - active_idx 0→5 and the period switches to 56818 cycles.
  - Release A4: fall back to active_idx=0 with period 95419, each change pulsing note_change once.
- Press D4 and G4 in the same cycle (keys 8'h00→8'h12):
  - active_idx=4.
  - Release G4: active_idx=1.
  - Release D4: note_on=0, tone=0, active_idx=0.
- Toggle keys[7] for 1000-cycle bursts (< DEBOUNCE_CYCLES):
  - note_on stays 0, no note_change, tone stays 0.
- Sound C5, assert mute for 200000 cycles, deassert:
  - tone=0 during mute while note_on stays 1.
  - After unmute, toggles continue on the original 47801-cycle grid.
- Sound B4, assert reset for 1 cycle mid-half-period:
  - All outputs 0 on the next edge.
  - Note re-sounds only after a fresh DEBOUNCE_CYCLES+3 cycles with key still held.
